// File: rtl/apb4_csr_hub_pkg.sv
// Shared types and constants for the APB4 CSR hub.
// The privilege check is enabled by defining APB4_CSR_HUB_PROT_CHECK_EN.
package apb4_csr_hub_pkg;

  // The wait counter must be wide enough to hold WAIT_STATES (0..15).
  localparam int WCNT_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO,
    ERR_PRIV
  } err_cause_t;

endpackage

// File: rtl/apb4_csr_hub_reg.sv
// One CSR word: the software write updates strobed bytes; the hardware load
// fills every byte that software is not writing in the same cycle.
module apb4_csr_hub_reg
  import apb4_csr_hub_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_we,
  input  logic [DATA_WIDTH/8-1:0] sw_strb,
  input  logic [DATA_WIDTH-1:0]   sw_data,
  input  logic                    hw_we,
  input  logic [DATA_WIDTH-1:0]   hw_data,
  output logic [DATA_WIDTH-1:0]   q
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] q_reg;
  logic [DATA_WIDTH-1:0] q_next;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      assign q_next[gi*8 +: 8] = (sw_we && sw_strb[gi]) ? sw_data[gi*8 +: 8] :
                                 hw_we                  ? hw_data[gi*8 +: 8] :
                                                          q_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/apb4_csr_hub.sv
// APB4 slave exposing NUM_REGS CSR words with SW/HW update and access pulses.
// Define APB4_CSR_HUB_PROT_CHECK_EN to reject unprivileged access to PRIV_MASK words.
module apb4_csr_hub
  import apb4_csr_hub_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [63:0] RO_MASK     = '0,
  parameter logic [63:0] PRIV_MASK   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic [2:0]                     pprot,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS-1:0]            hw_wr_en,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wr_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            sw_wr_pulse,
  output logic [NUM_REGS-1:0]            sw_rd_pulse
);

  localparam int IDXW = ADDR_WIDTH - 2;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_STATES);

  state_t                state_reg;
  logic [WCNT_W-1:0]     cnt_reg;
  logic [NUM_REGS-1:0]   sw_wr_pulse_reg;
  logic [NUM_REGS-1:0]   sw_rd_pulse_reg;

  logic [IDXW-1:0]       idx;
  logic [NUM_REGS-1:0]   sel;
  logic [DATA_WIDTH-1:0] q_arr    [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_terms [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_mux;
  err_cause_t            err_cause;
  logic                  xfer_err;
  logic                  access_end;
  logic                  commit_wr;
  logic                  commit_rd;

  assign idx = paddr[ADDR_WIDTH-1:2];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // One-hot decode; an index beyond NUM_REGS leaves sel all-zero.
      assign sel[gi]      = (idx == IDXW'(gi));
      assign rd_terms[gi] = sel[gi] ? q_arr[gi] : '0;
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = q_arr[gi];

      apb4_csr_hub_reg #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_reg (
        .clk     (clk),
        .rst     (rst),
        .sw_we   (commit_wr && sel[gi]),
        .sw_strb (pstrb),
        .sw_data (pwdata),
        .hw_we   (hw_wr_en[gi]),
        .hw_data (hw_wr_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .q       (q_arr[gi])
      );
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_mux = rd_mux | rd_terms[i];
    end
  end

  always_comb begin
    err_cause = ERR_NONE;
    if (paddr[1:0] != 2'b00) begin
      err_cause = ERR_ALIGN;
    end else if (!(|sel)) begin
      err_cause = ERR_RANGE;
    end else if (pwrite && (|(sel & RO_MASK[NUM_REGS-1:0]))) begin
      err_cause = ERR_RO;
`ifdef APB4_CSR_HUB_PROT_CHECK_EN
    end else if (!pprot[0] && (|(sel & PRIV_MASK[NUM_REGS-1:0]))) begin
      err_cause = ERR_PRIV;
`endif
    end
  end

`ifdef APB4_CSR_HUB_PROT_CHECK_EN
  logic unused_prot;
  assign unused_prot = ^pprot[2:1];
`else
  logic unused_prot;
  assign unused_prot = ^{pprot, PRIV_MASK};
`endif

  assign xfer_err   = (err_cause != ERR_NONE);
  // pready is combinational so a zero-wait slave completes in the first access cycle.
  assign access_end = !rst && (state_reg == ST_ACCESS) && psel && penable && (cnt_reg == '0);
  assign commit_wr  = access_end && pwrite && !xfer_err;
  assign commit_rd  = access_end && !pwrite && !xfer_err;

  assign pready      = access_end;
  assign pslverr     = access_end && xfer_err;
  assign prdata      = commit_rd ? rd_mux : '0;
  assign sw_wr_pulse = sw_wr_pulse_reg;
  assign sw_rd_pulse = sw_rd_pulse_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      sw_wr_pulse_reg <= '0;
      sw_rd_pulse_reg <= '0;
    end else begin
      sw_wr_pulse_reg <= commit_wr ? sel : '0;
      sw_rd_pulse_reg <= commit_rd ? sel : '0;
      case (state_reg)
        ST_IDLE: begin
          if (psel && !penable) begin
            state_reg <= ST_ACCESS;
            cnt_reg   <= WAIT_LOAD;
          end
        end
        ST_ACCESS: begin
          if (!psel) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else if (!penable) begin
            // A repeated setup phase restarts the wait count.
            cnt_reg <= WAIT_LOAD;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule
